rtc_time_base: RTL
==================

Name: rtc_time_base

Overview:
- Parametrised, synthesizable time base that replaces the behavioural fixed-period simulation clock.
- Divides the system clock down to a one-cycle tick at TICK_HZ.
- Keeps a BCD hh:mm:ss time-of-day count in 24h or 12h mode, with run/pause and synchronous time-set.
- Sits between the board clock and the display/alarm logic.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 1, advance rate of the seconds count. DIV = CLK_HZ/TICK_HZ must be an integer >= 2; elaboration fails otherwise.
- CNT_W, 26, prescaler width. Must satisfy 2^CNT_W >= DIV; elaboration fails otherwise.
- MODE_12H, 0, 0 = 24h format (00..23), 1 = 12h format (12,01..11 plus pm flag).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  1 = prescaler counts; 0 = prescaler and time hold.
- set_en  in  1  one-cycle request to load set_h/set_m/set_s/set_pm.
- set_h  in  8  hours, BCD.
- set_m  in  8  minutes, BCD.
- set_s  in  8  seconds, BCD.
- set_pm  in  1  pm flag for set; ignored when MODE_12H=0.
- hh  out  8  hours, BCD.
- mm  out  8  minutes, BCD.
- ss  out  8  seconds, BCD.
- pm  out  1  pm flag; constant 0 when MODE_12H=0.
- tick  out  1  one-cycle pulse each time the seconds count advances.
- min_wrap  out  1  one-cycle pulse when ss wraps 59 -> 00.
- day_wrap  out  1  one-cycle pulse at midnight rollover.
- set_err  out  1  one-cycle pulse when a set request is rejected.

Behaviour:
- Reset (async assert, sync release):
  - prescaler = 0; ss = mm = 0x00; pm = 0.
  - hh = 0x00 (24h) or 0x12 (12h).
  - tick, min_wrap, day_wrap, set_err = 0.
- Prescaler:
  - With run=1 and set_en=0, p increments each cycle.
  - When p == DIV-1: p <= 0 and the time advances on that same edge.
  - With run=0, p holds.
- Pulse outputs: tick, min_wrap and day_wrap are registered. They are high for exactly the one cycle following the advance edge, aligned with the updated hh/mm/ss.
- First advance: occurs exactly DIV cycles after reset release with run held high; advances are then periodic at DIV cycles.
- Advance rules:
  - ss counts 00..59. On wrap, mm+1 and min_wrap=1.
  - mm counts 00..59. On wrap, hh+1.
  - 24h mode: hh counts 00..23; 23:59:59 -> 00:00:00 with day_wrap=1.
  - 12h mode: hh sequence is 12,01,..,11,12.
    - 11:59:59 -> 12:00:00 toggles pm.
    - day_wrap=1 only on the pm=1 -> pm=0 transition.
  - Lower digit counts 0..9; upper digit increments on lower-digit carry. Non-BCD values never appear.
- Set:
  - set_en has priority over an advance in the same cycle; that advance is discarded and no tick is produced.
  - Valid request: loads the time and clears p to 0.
  - Validity requires every nibble <= 9, s <= 0x59 and m <= 0x59.
  - Hour validity: h <= 0x23 (24h), or 0x01 <= h <= 0x12 (12h).
  - Invalid request: time and p unchanged; set_err=1 for the next cycle.
  - Set is accepted regardless of run.
- Pause: run deasserted mid-count freezes p. Resume continues from the frozen p, so the remaining interval is DIV - p cycles, not DIV.
- Reset mid-count: all state returns to reset values immediately, without waiting for clk.

Decomposition:
- Shared package rtc_pkg:
  - bcd8_t typedef (two BCD nibbles).
  - Constants BCD_59, BCD_23, BCD_12, BCD_01.
  - Function bcd_valid(bcd8_t, max) returning validity.
- One natural sub-module, bcd_mod_counter:
  - Two-digit BCD counter with parameters MIN/MAX.
  - Ports: inc, load, load_val; outputs q, wrap.
  - Instantiated for ss, mm and hh; the 12h hour sequence is handled by MIN=1 plus the 11->12 pm-toggle logic in the parent.

Test Plan:
- CLK_HZ=4, TICK_HZ=1, run=1 from reset release -> tick at cycles 4, 8, 12; ss = 01, 02, 03; no min_wrap.
- Set 23:59:58 (24h, DIV=4), run=1 -> two ticks later hh:mm:ss = 00:00:00 with min_wrap=1 and day_wrap=1 in the same cycle.
- MODE_12H=1, set 11:59:59 pm=0 -> next tick 12:00:00 pm=1, day_wrap=0. Set 11:59:59 pm=1 -> next tick 12:00:00 pm=0, day_wrap=1.
- Set 0x24 hours in 24h mode, or 0x5A seconds -> set_err pulse for 1 cycle; time unchanged; prescaler not cleared.
- Pause/resume: drop run at p=2 for 10 cycles, then raise -> next tick exactly 2 cycles after resume; set_en coincident with p=DIV-1 -> set value loaded, no tick.
- Assert rst asynchronously mid-count (between clk edges) -> outputs reset immediately; after release the first tick arrives DIV cycles later.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC time base: two-digit BCD values
// and the validity check applied to time-set requests.
package rtc_pkg;

  typedef logic [7:0] bcd8_t;

  localparam bcd8_t BCD_59 = 8'h59;
  localparam bcd8_t BCD_23 = 8'h23;
  localparam bcd8_t BCD_12 = 8'h12;
  localparam bcd8_t BCD_01 = 8'h01;

  // Both nibbles must be decimal digits; for valid BCD the binary compare
  // against max orders the same way as the decimal values.
  function automatic logic bcd_valid(input bcd8_t v, input bcd8_t max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter running MIN..MAX with synchronous load; wrap is a
// combinational flag marking the increment that returns the count to MIN.
module bcd_mod_counter
  import rtc_pkg::*;
#(
  parameter bcd8_t MIN     = 8'h00,
  parameter bcd8_t MAX     = BCD_59,
  parameter bcd8_t RST_VAL = MIN
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  inc,
  input  logic  load,
  input  bcd8_t load_val,
  output bcd8_t q,
  output logic  wrap
);

  bcd8_t r_q;

  // NOTE: state registers use non-blocking assignments so every flop in the
  // design samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else if (load) begin
      r_q <= load_val;
    end else if (inc) begin
      if (r_q == MAX)
        r_q <= MIN;
      else if (r_q[3:0] == 4'd9)
        r_q <= {r_q[7:4] + 4'd1, 4'd0};
      else
        r_q <= r_q + 8'd1;
    end
  end

  assign q    = r_q;
  assign wrap = inc && (r_q == MAX);

endmodule

// File: rtl/rtc_time_base.sv
// Prescaled time-of-day base: divides clk to a tick and keeps a BCD
// hh:mm:ss count (24h or 12h with pm flag) with run/pause and time-set.
module rtc_time_base
  import rtc_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1,
  parameter int CNT_W    = 26,
  parameter int MODE_12H = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       set_en,
  input  logic [7:0] set_h,
  input  logic [7:0] set_m,
  input  logic [7:0] set_s,
  input  logic       set_pm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       tick,
  output logic       min_wrap,
  output logic       day_wrap,
  output logic       set_err
);

  localparam int             DIV    = CLK_HZ / TICK_HZ;
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(DIV - 1);
  localparam logic           IS_12H = (MODE_12H != 0);
  localparam bcd8_t          H_MIN  = IS_12H ? BCD_01 : 8'h00;
  localparam bcd8_t          H_MAX  = IS_12H ? BCD_12 : BCD_23;
  localparam bcd8_t          H_RST  = IS_12H ? BCD_12 : 8'h00;

  generate
    if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
      $error("rtc_time_base: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
    if (longint'(DIV) > (longint'(1) << CNT_W)) begin : g_bad_cnt_w
      $error("rtc_time_base: CNT_W too narrow for CLK_HZ/TICK_HZ");
    end
  endgenerate

  logic [CNT_W-1:0] r_p;
  logic             r_pm, r_tick, r_min_wrap, r_day_wrap, r_set_err;
  bcd8_t            w_ss, w_mm, w_hh;
  logic             w_set_ok, w_load, w_adv;
  logic             w_s_wrap, w_m_wrap, w_h_wrap, w_pm_flip, w_day;

  // In 12h mode hour 00 is illegal, which is the only lower-bound case.
  assign w_set_ok = bcd_valid(set_s, BCD_59) && bcd_valid(set_m, BCD_59) &&
                    bcd_valid(set_h, H_MAX) && (!IS_12H || set_h != 8'h00);
  assign w_load   = set_en && w_set_ok;
  assign w_adv    = run && !set_en && (r_p == P_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_p <= '0;
    else if (w_load)
      r_p <= '0;
    else if (run && !set_en)
      r_p <= w_adv ? '0 : r_p + CNT_W'(1);
  end

  bcd_mod_counter #(.MIN(8'h00), .MAX(BCD_59), .RST_VAL(8'h00)) u_ss (
    .clk(clk), .rst(rst), .inc(w_adv), .load(w_load), .load_val(set_s),
    .q(w_ss), .wrap(w_s_wrap)
  );

  bcd_mod_counter #(.MIN(8'h00), .MAX(BCD_59), .RST_VAL(8'h00)) u_mm (
    .clk(clk), .rst(rst), .inc(w_s_wrap), .load(w_load), .load_val(set_m),
    .q(w_mm), .wrap(w_m_wrap)
  );

  bcd_mod_counter #(.MIN(H_MIN), .MAX(H_MAX), .RST_VAL(H_RST)) u_hh (
    .clk(clk), .rst(rst), .inc(w_m_wrap), .load(w_load), .load_val(set_h),
    .q(w_hh), .wrap(w_h_wrap)
  );

  // 12h: the 11 -> 12 step flips am/pm; the day ends on the pm -> am flip.
  assign w_pm_flip = IS_12H && w_m_wrap && (w_hh == 8'h11);
  assign w_day     = IS_12H ? (w_pm_flip && r_pm) : w_h_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pm       <= 1'b0;
      r_tick     <= 1'b0;
      r_min_wrap <= 1'b0;
      r_day_wrap <= 1'b0;
      r_set_err  <= 1'b0;
    end else begin
      if (w_load)
        r_pm <= IS_12H && set_pm;
      else if (w_pm_flip)
        r_pm <= !r_pm;
      r_tick     <= w_adv;
      r_min_wrap <= w_s_wrap;
      r_day_wrap <= w_day;
      r_set_err  <= set_en && !w_set_ok;
    end
  end

  assign hh       = w_hh;
  assign mm       = w_mm;
  assign ss       = w_ss;
  assign pm       = r_pm;
  assign tick     = r_tick;
  assign min_wrap = r_min_wrap;
  assign day_wrap = r_day_wrap;
  assign set_err  = r_set_err;

endmodule
